// File: rtl/spi_csr_if.sv
// Register request bus between spi_slave and the logic-domain CSR responder.
//   wen/ren : single-cycle write/read request pulses
//   addr    : register address (AW bits)
//   wdata   : write data (DW bits)
//   rdata   : registered read data, holds until the next read
//   rvalid  : one-cycle pulse marking rdata valid
// master: the requester (spi_slave side); slave: the responder.
interface spi_csr_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) ();
  logic          wen;
  logic          ren;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (output wen, ren, addr, wdata, input  rdata, rvalid);
  modport slave  (input  wen, ren, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/spi_csr_responder.sv
// CSR responder behind spi_slave: config/status registers, command strobe,
// W1C event flags and two byte FIFOs (host->core TX, core->host RX).
// Ports:
//   clk, rst_slave   : clock, asynchronous active-high reset
//   bus              : register request bus (spi_csr_if.slave)
//   cfg_q            : config regs 0x0-0x7, reg n at [n*DW +: DW]
//   start_pulse      : one-cycle core start after a CMD write with bit0 set
//   busy, done       : core status level / completion pulse
//   tx_data/valid/ready : host->core FIFO head and pop handshake
//   rx_data/valid/ready : core->host FIFO push handshake
module spi_csr_responder #(
  parameter int unsigned   DW         = 8,
  parameter int unsigned   AW         = 4,
  parameter int unsigned   FIFO_DEPTH = 4,
  parameter logic [DW-1:0] ID_VALUE   = 'h3C
) (
  input  logic            clk,
  input  logic            rst_slave,
  spi_csr_if.slave        bus,
  output logic [8*DW-1:0] cfg_q,
  output logic            start_pulse,
  input  logic            busy,
  input  logic            done,
  output logic [DW-1:0]   tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  input  logic [DW-1:0]   rx_data,
  input  logic            rx_valid,
  output logic            rx_ready
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [AW-1:0] A_CFG_END = AW'(8);
  localparam logic [AW-1:0] A_CMD     = AW'(8);
  localparam logic [AW-1:0] A_STATUS  = AW'(9);
  localparam logic [AW-1:0] A_FLAGS   = AW'(10);
  localparam logic [AW-1:0] A_TX      = AW'(11);
  localparam logic [AW-1:0] A_RX      = AW'(12);
  localparam logic [AW-1:0] A_RXCNT   = AW'(13);
  localparam logic [AW-1:0] A_ID      = AW'(14);
  localparam logic [AW-1:0] A_SCRATCH = AW'(15);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  logic [DW-1:0] scratch;
  logic          done_flag, tx_ovf, rx_udf;

  logic [DW-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr, tx_rd;
  logic [CW-1:0] tx_cnt;
  logic [DW-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr, rx_rd;
  logic [CW-1:0] rx_cnt;

  logic          wr_en, rd_en;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push_req, tx_push, tx_pop;
  logic          rx_pop_req, rx_pop, rx_push;
  logic [2:0]    flag_clr;
  logic [7:0]    status;
  logic [DW-1:0] rd_mux;

  // Request decode and FIFO handshakes; a write wins over a same-cycle read.
  always_comb begin
    wr_en       = bus.wen;
    rd_en       = bus.ren & ~bus.wen;
    tx_full     = (tx_cnt == CNT_FULL);
    tx_empty    = (tx_cnt == '0);
    rx_full     = (rx_cnt == CNT_FULL);
    rx_empty    = (rx_cnt == '0);
    tx_pop      = ~tx_empty & tx_ready;
    tx_push_req = wr_en & (bus.addr == A_TX);
    // A full FIFO still takes the push when the core frees a slot this cycle.
    tx_push     = tx_push_req & (~tx_full | tx_pop);
    rx_push     = rx_valid & ~rx_full;
    rx_pop_req  = rd_en & (bus.addr == A_RX);
    rx_pop      = rx_pop_req & ~rx_empty;
    flag_clr    = (wr_en && bus.addr == A_FLAGS) ? bus.wdata[2:0] : 3'b000;
    status      = {busy, done_flag, tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_udf};
  end

  // Read data mux over pre-update state.
  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      A_CMD:     rd_mux = '0;
      A_STATUS:  rd_mux = DW'(status);
      A_FLAGS:   rd_mux = DW'({rx_udf, tx_ovf, done_flag});
      A_TX:      rd_mux = DW'(tx_cnt);
      A_RX:      rd_mux = rx_empty ? '0 : rx_mem[rx_rd];
      A_RXCNT:   rd_mux = DW'(rx_cnt);
      A_ID:      rd_mux = ID_VALUE;
      A_SCRATCH: rd_mux = scratch;
      default: begin
        if (bus.addr < A_CFG_END) rd_mux = cfg_q[32'(bus.addr[2:0]) * DW +: DW];
      end
    endcase
  end

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rd];
  assign rx_ready = ~rx_full;

  // Register file, flags and read response.
  always_ff @(posedge clk or posedge rst_slave) begin
    if (rst_slave) begin
      bus.rdata   <= '0;
      bus.rvalid  <= 1'b0;
      start_pulse <= 1'b0;
      cfg_q       <= '0;
      scratch     <= '0;
      done_flag   <= 1'b0;
      tx_ovf      <= 1'b0;
      rx_udf      <= 1'b0;
    end else begin
      bus.rvalid  <= rd_en;
      if (rd_en) bus.rdata <= rd_mux;
      start_pulse <= wr_en & (bus.addr == A_CMD) & bus.wdata[0];
      if (wr_en && bus.addr < A_CFG_END) cfg_q[32'(bus.addr[2:0]) * DW +: DW] <= bus.wdata;
      if (wr_en && bus.addr == A_SCRATCH) scratch <= bus.wdata;
      // Set beats a same-cycle write-one-to-clear.
      done_flag <= (done_flag & ~flag_clr[0]) | done;
      tx_ovf    <= (tx_ovf & ~flag_clr[1]) | (tx_push_req & ~tx_push);
      rx_udf    <= (rx_udf & ~flag_clr[2]) | (rx_pop_req & rx_empty);
    end
  end

  // Host->core FIFO.
  always_ff @(posedge clk or posedge rst_slave) begin
    if (rst_slave) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= '0;
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr] <= bus.wdata;
        tx_wr         <= tx_wr + PW'(1);
      end
      if (tx_pop) tx_rd <= tx_rd + PW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // Core->host FIFO.
  always_ff @(posedge clk or posedge rst_slave) begin
    if (rst_slave) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wr] <= rx_data;
        rx_wr         <= rx_wr + PW'(1);
      end
      if (rx_pop) rx_rd <= rx_rd + PW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end
endmodule

// File: tb/tb_spi_csr_responder.sv
// Self-checking bench for spi_csr_responder: hand-derived vector table,
// directed multi-cycle sequences and randomized traffic, all shadowed by a
// queue-based reference model compared every cycle.
module tb_spi_csr_responder;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned D  = 4;

  logic clk = 1'b0;
  logic rst_slave;
  always #5 clk = ~clk;

  spi_csr_if #(.AW(AW), .DW(DW)) bus ();
  logic [8*DW-1:0] cfg_q;
  logic            start_pulse, busy, done;
  logic [DW-1:0]   tx_data, rx_data;
  logic            tx_valid, tx_ready, rx_valid, rx_ready;

  spi_csr_responder #(.DW(DW), .AW(AW), .FIFO_DEPTH(D), .ID_VALUE(8'h3C)) dut (
    .clk(clk), .rst_slave(rst_slave), .bus(bus.slave),
    .cfg_q(cfg_q), .start_pulse(start_pulse), .busy(busy), .done(done),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_cfg [8];
  logic [7:0] m_scr, m_rdata;
  bit         m_done, m_ovf, m_udf, m_rvalid, m_start;
  logic [7:0] txq [$];
  logic [7:0] rxq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_cfg[i] = 8'h00;
    m_scr = 0; m_rdata = 0; m_done = 0; m_ovf = 0; m_udf = 0; m_rvalid = 0; m_start = 0;
    txq.delete(); rxq.delete();
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a);
    case (a)
      4'h8: return 8'h00;
      4'h9: return {busy, m_done, txq.size() == D, txq.size() == 0,
                    rxq.size() == D, rxq.size() == 0, m_ovf, m_udf};
      4'hA: return {5'b0, m_udf, m_ovf, m_done};
      4'hB: return 8'(txq.size());
      4'hC: return (rxq.size() > 0) ? rxq[0] : 8'h00;
      4'hD: return 8'(rxq.size());
      4'hE: return 8'h3C;
      4'hF: return m_scr;
      default: return m_cfg[a[2:0]];
    endcase
  endfunction

  // One clock edge of the specified behaviour, using the inputs presented.
  function automatic void model_step();
    bit wr, rd, txpop, rxpush, tx_accept, ovf_set, udf_set;
    logic [2:0] clr;
    logic [7:0] rv;
    wr = bus.wen;
    rd = bus.ren && !bus.wen;
    rv = m_read(bus.addr);
    txpop = (txq.size() > 0) && tx_ready;
    rxpush = rx_valid && (rxq.size() < D);
    tx_accept = (txq.size() < D) || txpop;
    ovf_set = 0; udf_set = 0;
    clr = (wr && bus.addr == 4'hA) ? bus.wdata[2:0] : 3'b000;
    m_rvalid = rd;
    if (rd) m_rdata = rv;
    m_start = wr && bus.addr == 4'h8 && bus.wdata[0];
    if (wr && bus.addr < 4'h8) m_cfg[bus.addr[2:0]] = bus.wdata;
    if (wr && bus.addr == 4'hF) m_scr = bus.wdata;
    if (txpop) void'(txq.pop_front());
    if (wr && bus.addr == 4'hB) begin
      if (tx_accept) txq.push_back(bus.wdata);
      else ovf_set = 1;
    end
    if (rd && bus.addr == 4'hC) begin
      if (rxq.size() == 0) udf_set = 1;
      else void'(rxq.pop_front());
    end
    if (rxpush) rxq.push_back(rx_data);
    m_done = (m_done && !clr[0]) || done;
    m_ovf  = (m_ovf && !clr[1]) || ovf_set;
    m_udf  = (m_udf && !clr[2]) || udf_set;
  endfunction

  task automatic compare();
    logic [63:0] e;
    for (int i = 0; i < 8; i++) e[i*8 +: 8] = m_cfg[i];
    chk("rvalid", bus.rvalid, m_rvalid);
    chk("rdata", bus.rdata, m_rdata);
    chk("start_pulse", start_pulse, m_start);
    chk("cfg_q", cfg_q, e);
    chk("tx_valid", tx_valid, txq.size() > 0);
    if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
    chk("rx_ready", rx_ready, rxq.size() < D);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle_bus();
    bus.wen = 0; bus.ren = 0; bus.addr = 0; bus.wdata = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.wen = 1; bus.ren = 0; bus.addr = a; bus.wdata = d;
    cycle();
    idle_bus();
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    bus.wen = 0; bus.ren = 1; bus.addr = a; bus.wdata = 0;
    cycle();
    idle_bus();
    chk("rd_rvalid", bus.rvalid, 1'b1);
    v = bus.rdata;
  endtask

  typedef struct {
    bit         w;
    bit         r;
    logic [3:0] a;
    logic [7:0] d;
    int         k;   // 0: no check, 1: expect read data, 2: expect no rvalid
    logic [7:0] e;
  } vec_t;

  vec_t tbl [$];
  logic [7:0] v;
  logic [7:0] got [$];
  logic [7:0] exp_tx [5];

  initial begin
    rst_slave = 1; idle_bus();
    busy = 0; done = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_slave = 0;
    compare();

    // Directed vectors with hand-derived read values
    tbl.push_back('{0, 1, 4'hE, 8'h00, 1, 8'h3C});
    tbl.push_back('{0, 1, 4'h9, 8'h00, 1, 8'h14});
    tbl.push_back('{0, 1, 4'h0, 8'h00, 1, 8'h00});
    tbl.push_back('{1, 0, 4'h3, 8'hA5, 0, 8'h00});
    tbl.push_back('{1, 0, 4'hF, 8'h5A, 0, 8'h00});
    tbl.push_back('{0, 1, 4'h3, 8'h00, 1, 8'hA5});
    tbl.push_back('{0, 1, 4'hF, 8'h00, 1, 8'h5A});
    tbl.push_back('{1, 0, 4'hE, 8'hFF, 0, 8'h00});
    tbl.push_back('{0, 1, 4'hE, 8'h00, 1, 8'h3C});
    tbl.push_back('{1, 0, 4'hB, 8'h11, 0, 8'h00});
    tbl.push_back('{1, 0, 4'hB, 8'h22, 0, 8'h00});
    tbl.push_back('{1, 0, 4'hB, 8'h33, 0, 8'h00});
    tbl.push_back('{1, 0, 4'hB, 8'h44, 0, 8'h00});
    tbl.push_back('{1, 0, 4'hB, 8'h55, 0, 8'h00});
    tbl.push_back('{0, 1, 4'hB, 8'h00, 1, 8'h04});
    tbl.push_back('{0, 1, 4'h9, 8'h00, 1, 8'h26});
    tbl.push_back('{0, 1, 4'hA, 8'h00, 1, 8'h02});
    tbl.push_back('{1, 0, 4'hA, 8'h02, 0, 8'h00});
    tbl.push_back('{0, 1, 4'hA, 8'h00, 1, 8'h00});
    tbl.push_back('{0, 1, 4'hC, 8'h00, 1, 8'h00});
    tbl.push_back('{0, 1, 4'hA, 8'h00, 1, 8'h04});
    tbl.push_back('{1, 0, 4'hA, 8'h04, 0, 8'h00});
    tbl.push_back('{0, 1, 4'hA, 8'h00, 1, 8'h00});
    tbl.push_back('{1, 1, 4'h1, 8'h77, 2, 8'h00});
    tbl.push_back('{0, 1, 4'h1, 8'h00, 1, 8'h77});
    foreach (tbl[i]) begin
      bus.wen = tbl[i].w; bus.ren = tbl[i].r; bus.addr = tbl[i].a; bus.wdata = tbl[i].d;
      cycle();
      idle_bus();
      if (tbl[i].k == 1) begin
        chk($sformatf("tbl%0d_rvalid", i), bus.rvalid, 1'b1);
        chk($sformatf("tbl%0d_rdata", i), bus.rdata, tbl[i].e);
      end else if (tbl[i].k == 2) begin
        chk($sformatf("tbl%0d_no_rvalid", i), bus.rvalid, 1'b0);
      end
    end
    chk("cfg3_export", cfg_q[31:24], 8'hA5);

    // Start strobe is exactly one cycle
    wr(4'h8, 8'h01);
    chk("start_hi", start_pulse, 1'b1);
    cycle();
    chk("start_lo", start_pulse, 1'b0);
    chk("rvalid_one_cycle", bus.rvalid, 1'b0);

    // Full TX push with same-cycle core pop is accepted, then drain in order
    exp_tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
    tx_ready = 1;
    bus.wen = 1; bus.addr = 4'hB; bus.wdata = 8'h66;
    for (int n = 0; n < 10 && (tx_valid || n == 0); n++) begin
      if (tx_valid) got.push_back(tx_data);
      cycle();
      idle_bus();
    end
    tx_ready = 0;
    chk("tx_drain_len", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) chk($sformatf("tx_order%0d", i), got[i], exp_tx[i]);
    rd(4'hA, v); chk("no_ovf_on_pop_push", v, 8'h00);

    // done flag: set, set-wins over clear, clear
    done = 1; cycle(); done = 0;
    rd(4'h9, v); chk("status_done", v[6], 1'b1);
    done = 1; wr(4'hA, 8'h01); done = 0;
    rd(4'hA, v); chk("done_set_wins", v[0], 1'b1);
    wr(4'hA, 8'h01);
    rd(4'hA, v); chk("done_cleared", v, 8'h00);

    // RX FIFO ordering, underflow, concurrent push/pop
    rx_valid = 1; rx_data = 8'hDE; cycle();
    rx_data = 8'hAD; cycle();
    rx_valid = 0;
    rd(4'hD, v); chk("rx_cnt2", v, 8'h02);
    rd(4'hC, v); chk("rx_pop_de", v, 8'hDE);
    rd(4'hC, v); chk("rx_pop_ad", v, 8'hAD);
    rd(4'hC, v); chk("rx_pop_empty", v, 8'h00);
    rd(4'hA, v); chk("rx_udf", v, 8'h04);
    wr(4'hA, 8'h04);
    rx_valid = 1; rx_data = 8'h01; cycle();
    rx_data = 8'h02; bus.ren = 1; bus.addr = 4'hC;
    cycle();
    idle_bus(); rx_valid = 0;
    chk("rx_pushpop_data", bus.rdata, 8'h01);
    rd(4'hD, v); chk("rx_pushpop_cnt", v, 8'h01);
    rd(4'hC, v); chk("rx_last", v, 8'h02);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.wen   = ($urandom_range(3) == 0);
      bus.ren   = ($urandom_range(3) == 0);
      bus.addr  = 4'($urandom_range(15));
      bus.wdata = 8'($urandom);
      busy      = 1'($urandom);
      done      = ($urandom_range(7) == 0);
      tx_ready  = 1'($urandom);
      rx_valid  = 1'($urandom);
      rx_data   = 8'($urandom);
      cycle();
    end
    idle_bus(); busy = 0; done = 0; tx_ready = 0; rx_valid = 0;
    cycle();

    // Asynchronous reset in the middle of a cycle with live state
    wr(4'h3, 8'hFF);
    wr(4'hF, 8'h77);
    wr(4'hB, 8'h11);
    rx_valid = 1; rx_data = 8'h99; done = 1; cycle();
    rx_valid = 0; done = 0;
    bus.ren = 1; bus.addr = 4'hF; cycle(); idle_bus();
    #2 rst_slave = 1;
    #1;
    model_reset();
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_start", start_pulse, 1'b0);
    chk("rst_cfg", cfg_q, 64'h0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);
    @(posedge clk);
    #1 rst_slave = 0;
    compare();
    rd(4'hF, v); chk("rst_scratch", v, 8'h00);
    rd(4'h9, v); chk("rst_status", v, 8'h14);
    rd(4'hA, v); chk("rst_flags", v, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_csr_responder.md
# spi_csr_responder

Logic-domain register responder behind `spi_slave`. It services the slave's `wen`/`ren`/`addr`/`wdata` requests and returns `rdata`/`rvalid`. It holds configuration and status registers for the core and two small byte FIFOs (host→core, core→host), so the FPGA host can configure the core, start it, and stream bytes over SPI. All logic runs on `clk`.

## Interface
- `DW`, 8, data width (equals `spi_slave` DW)
- `AW`, 4, register address width (16 locations)
- `FIFO_DEPTH`, 4, entries per FIFO (power of 2, ≥2)
- `ID_VALUE`, 8'h3C, constant returned at address 0xE
- `clk`  in  1  logic clock
- `rst_slave`  in  1  reset, asynchronous, active-high
- `wen`  in  1  write request from `spi_slave`, single-cycle pulse
- `ren`  in  1  read request from `spi_slave`, single-cycle pulse
- `addr`  in  AW  register address
- `wdata`  in  DW  write data
- `rdata`  out  DW  read data, registered
- `rvalid`  out  1  one-cycle pulse, `rdata` valid
- `cfg_q`  out  8*DW  config regs 0x0–0x7; reg n at bits [n*DW +: DW]
- `start_pulse`  out  1  one-cycle core start
- `busy`  in  1  core busy level
- `done`  in  1  core done pulse
- `tx_data`  out  DW  host→core FIFO head
- `tx_valid`  out  1  host→core FIFO non-empty
- `tx_ready`  in  1  core pops when `tx_valid & tx_ready`
- `rx_data`  in  DW  core→host byte
- `rx_valid`  in  1  core push request
- `rx_ready`  out  1  core→host FIFO not full

## Operation
- Address map:
  - 0x0–0x7 CFG: RW, reset 0
  - 0x8 CMD: WO; writing with wdata[0]=1 makes `start_pulse` fire the next cycle; reads return 0
  - 0x9 STATUS: RO, {busy, done_flag, tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_udf}, MSB first
  - 0xA FLAGS: W1C; bit0 done_flag, bit1 tx_ovf, bit2 rx_udf; reads return {5'b0, rx_udf, tx_ovf, done_flag}
  - 0xB TX_PUSH: a write pushes wdata to the TX FIFO; a read returns the TX count
  - 0xC RX_POP: a read returns the RX head and pops it
  - 0xD RX_CNT: RO
  - 0xE ID: RO, returns ID_VALUE
  - 0xF SCRATCH: RW, not exported
- Writes to RO addresses are ignored.
- `wen` and `ren` in the same cycle: the write executes and `ren` is ignored (no `rvalid`).
- TX push when full: data dropped, tx_ovf set. Exception: when full and the core pops in the same cycle, the push is accepted and the count is unchanged.
- RX_POP when empty: `rdata`=0, rx_udf set, no pointer change.
- RX push and pop in the same cycle: both happen, count unchanged; `rx_ready` is based on the current count.
- `done` sets done_flag. A same-cycle W1C on that bit loses: set wins. The same rule applies to tx_ovf and rx_udf.
- Counts are width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- Register fields narrower than DW are zero-extended.

## Timing
- Read latency 1: `ren` at cycle N gives `rvalid`=1 and valid `rdata` at N+1. `rdata` holds until the next read. `rvalid` is high for exactly one cycle.
- Write takes effect at the clock edge sampling `wen`. `cfg_q`/SCRATCH are visible at N+1. `start_pulse` is high at N+1 only.
- Reads return pre-update state. Example: an RX_POP read at N returns the head as of N; the count drops at N+1.
- `tx_data`/`tx_valid` are registered FIFO outputs; `tx_valid` rises the cycle after the first push.
- Reset (async, any time, including mid-transfer) clears:
  - `rdata`=0, `rvalid`=0, `start_pulse`=0, `cfg_q`=0
  - all flags, both FIFOs empty (`tx_valid`=0, `rx_ready`=1)
  - SCRATCH=0
- Back-to-back requests on consecutive cycles are supported.

## Test plan
- Reset checks: after reset, read 0xE → 0x3C, 0x9 → 8'h14 (tx_empty, rx_empty), 0x0 → 0x00; `rvalid` is exactly 1 cycle after each `ren`.
- CFG/SCRATCH: write 0x3=0xA5 and 0xF=0x5A → `cfg_q[31:24]`=0xA5; reads return 0xA5/0x5A; write to 0xE then read → still 0x3C.
- CMD/done: write 0x8=0x01 → one `start_pulse`; pulse `done` → STATUS bit6=1; write 0xA=0x01 → cleared. `done` coinciding with the W1C → flag stays set.
- TX FIFO: with `tx_ready`=0, push 0x11,0x22,0x33,0x44,0x55 → 0x55 dropped, tx_ovf=1, count=4. With `tx_ready`=1 the core sees 0x11..0x44 in order. Full push plus same-cycle pop → accepted.
- RX FIFO: core pushes 0xDE,0xAD → RX_CNT=2; pops return 0xDE, 0xAD; a third pop returns 0 and sets rx_udf; push and pop in one cycle keep the count.
- Reset asserted mid-stream (FIFOs partly full, flags set) → all outputs return to reset values within the same cycle.
